// File: rtl/register_pipe_vr.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and
// an occupancy counter. Outputs come straight from the last stage registers.
module register_pipe_vr #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           DEPTH     = 2,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  localparam int unsigned          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] vin;
  logic [WIDTH-1:0] din [DEPTH];
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_n;

  // Ready chain is built with a running variable so no vector bit feeds
  // another bit of the same vector.
  always_comb begin
    logic r;
    ready        = '0;
    r            = m_ready;
    ready[DEPTH] = m_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r        = !valid[k] | r;
      ready[k] = r;
    end
  end

  always_comb begin
    vin    = '0;
    vin[0] = s_valid;
    din[0] = s_data;
    for (int k = 1; k < DEPTH; k++) begin
      vin[k] = valid[k-1];
      din[k] = data[k-1];
    end
  end

  assign s_ready  = ready[0] & !flush;
  assign m_valid  = valid[DEPTH-1];
  assign m_data   = data[DEPTH-1];
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;
  assign count_n  = count + CNT_W'(in_xfer) - CNT_W'(out_xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) data[k] <= RESET_VAL;
    end else if (flush) begin
      // Data registers are intentionally left as they are on flush.
      valid <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid[k] <= vin[k];
          if (vin[k]) data[k] <= din[k];
        end
      end
      count <= count_n;
    end
  end

endmodule
